muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/selector.sv | 12 +
 rtl/muldiv_unit.sv | 155 +++++++++++++++
 tb/tb_muldiv_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/selector.sv
// selector: operation encodings shared between decode and the execute-stage units.
package selector;

    typedef enum logic [2:0] {
        MULDIV_MULT,
        MULDIV_MULTU,
        MULDIV_DIV,
        MULDIV_DIVU,
        MULDIV_NCARE
    } muldiv_funct_t;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit with a 32-step restoring divider.
// Define MULDIV_ITER_MULT_EN to replace the single-cycle multiplier with a 32-step shift-add.
module muldiv_unit
    import selector::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  muldiv_funct_t funct,
    input  logic [31:0]   src_a,
    input  logic [31:0]   src_b,
    input  logic          flush,
    output logic          busy,
    output logic          done,
    output logic [31:0]   hi,
    output logic [31:0]   lo
);

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] b_q;
    logic        neg_q, neg_r, is_div_q;
    logic        busy_q, done_q;

    logic        accept, is_signed, is_div, sign_a, sign_b;
    logic [31:0] mag_a, mag_b;

    assign accept    = start && !flush && (funct != MULDIV_NCARE) &&
                       ((state_q == StIdle) || (state_q == StDone));
    assign is_signed = (funct == MULDIV_MULT) || (funct == MULDIV_DIV);
    assign is_div    = (funct == MULDIV_DIV) || (funct == MULDIV_DIVU);
    assign sign_a    = is_signed & src_a[31];
    assign sign_b    = is_signed & src_b[31];
    assign mag_a     = sign_a ? -src_a : src_a;
    assign mag_b     = sign_b ? -src_b : src_b;

    // Restoring step: the partial remainder stays below the divisor, so bit 32 is the borrow.
    logic [32:0] div_shift, div_diff;
    logic        q_bit;
    assign div_shift = {rem_q, quo_q[31]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign q_bit     = ~div_diff[32];

    logic [63:0] mul_raw, mul_fix;
`ifdef MULDIV_ITER_MULT_EN
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, rem_q} + {1'b0, (quo_q[0] ? b_q : 32'd0)};
    assign mul_raw = {rem_q, quo_q};
`else
    assign mul_raw = {32'd0, quo_q} * {32'd0, b_q};
`endif
    assign mul_fix = neg_q ? -mul_raw : mul_raw;

    logic [31:0] quo_fix, rem_fix;
    assign quo_fix = neg_q ? -quo_q : quo_q;
    assign rem_fix = neg_r ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            StIdle: ;
            StMul: begin
`ifdef MULDIV_ITER_MULT_EN
                rem_d = mul_sum[32:1];
                quo_d = {mul_sum[0], quo_q[31:1]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = StFix;
`else
                {hi_d, lo_d} = mul_fix;
                state_d      = StDone;
`endif
            end
            StDiv: begin
                rem_d = q_bit ? div_diff[31:0] : div_shift[31:0];
                quo_d = {quo_q[30:0], q_bit};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = StFix;
            end
            StFix: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    {hi_d, lo_d} = mul_fix;
                end
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (accept) begin
            state_d = is_div ? StDiv : StMul;
            cnt_d   = 6'd0;
            rem_d   = 32'd0;
            quo_d   = mag_a;
        end
        // Abort discards the in-flight result; HI/LO keep their committed values.
        if (flush) begin
            state_d = StIdle;
            cnt_d   = 6'd0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 6'd0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            b_q      <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_div_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d == StMul) || (state_d == StDiv) || (state_d == StFix);
            done_q  <= (state_d == StDone);
            if (accept) begin
                b_q      <= mag_b;
                // A zero divisor must yield an all-ones quotient regardless of sign.
                neg_q    <= (sign_a ^ sign_b) & (|src_b);
                neg_r    <= sign_a;
                is_div_q <= is_div;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    import selector::*;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          flush = 1'b0;
    muldiv_funct_t funct = MULDIV_NCARE;
    logic [31:0]   src_a = 32'd0;
    logic [31:0]   src_b = 32'd0;
    logic          busy, done;
    logic [31:0]   hi, lo;

    int total  = 0;
    int passed = 0;

`ifdef MULDIV_ITER_MULT_EN
    localparam int MulLat = 33;
`else
    localparam int MulLat = 1;
`endif
    localparam int DivLat = 33;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .funct (funct),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Called at a falling edge; returns at the falling edge right after the accepting edge.
    task automatic issue(input muldiv_funct_t f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        funct = f;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
        funct = MULDIV_NCARE;
    endtask

    task automatic wait_done(output int k, output int nb);
        k  = 0;
        nb = 0;
        while (done !== 1'b1 && k < 80) begin
            if (busy === 1'b1) nb++;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        #2;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
        total++; if (hi !== 32'd0) $display("FAIL reset_hi: got %h expected 0", hi); else passed++;
        total++; if (lo !== 32'd0) $display("FAIL reset_lo: got %h expected 0", lo); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int k, nb;
        issue(MULDIV_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_done(k, nb);
        total++; if (k != MulLat) $display("FAIL mult_latency: got %0d expected %0d", k, MulLat); else passed++;
        total++; if (nb != MulLat) $display("FAIL mult_busy: got %0d expected %0d", nb, MulLat); else passed++;
        total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h expected ffffffff", hi); else passed++;
        total++; if (lo !== 32'hFFFF_FFFA) $display("FAIL mult_lo: got %h expected fffffffa", lo); else passed++;
        @(negedge clk);
        total++; if (done !== 1'b0) $display("FAIL mult_done_pulse: got %b expected 0", done); else passed++;
        total++; if (lo !== 32'hFFFF_FFFA) $display("FAIL mult_lo_hold: got %h expected fffffffa", lo); else passed++;
    endtask

    task automatic test_multu();
        int k, nb;
        issue(MULDIV_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(k, nb);
        total++; if (k != MulLat) $display("FAIL multu_latency: got %0d expected %0d", k, MulLat); else passed++;
        total++; if (hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi: got %h expected fffffffe", hi); else passed++;
        total++; if (lo !== 32'd1) $display("FAIL multu_lo: got %h expected 00000001", lo); else passed++;
        @(negedge clk);
    endtask

    task automatic test_div();
        int k, nb;
        issue(MULDIV_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(k, nb);
        total++; if (k != DivLat) $display("FAIL div_latency: got %0d expected %0d", k, DivLat); else passed++;
        total++; if (nb != 33) $display("FAIL div_busy: got %0d expected 33", nb); else passed++;
        total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_lo: got %h expected fffffffd", lo); else passed++;
        total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_hi: got %h expected ffffffff", hi); else passed++;
        @(negedge clk);
        issue(MULDIV_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_done(k, nb);
        total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_negb_lo: got %h expected fffffffd", lo); else passed++;
        total++; if (hi !== 32'd1) $display("FAIL div_negb_hi: got %h expected 00000001", hi); else passed++;
        @(negedge clk);
    endtask

    task automatic test_div_corner();
        int k, nb;
        issue(MULDIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(k, nb);
        total++; if (lo !== 32'h8000_0000) $display("FAIL div_ovf_lo: got %h expected 80000000", lo); else passed++;
        total++; if (hi !== 32'd0) $display("FAIL div_ovf_hi: got %h expected 00000000", hi); else passed++;
        @(negedge clk);
        issue(MULDIV_DIV, 32'hFFFF_FFFB, 32'd0);
        wait_done(k, nb);
        total++; if (k != DivLat) $display("FAIL div0_latency: got %0d expected %0d", k, DivLat); else passed++;
        total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL div0_lo: got %h expected ffffffff", lo); else passed++;
        total++; if (hi !== 32'hFFFF_FFFB) $display("FAIL div0_hi: got %h expected fffffffb", hi); else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int k, nb;
        issue(MULDIV_DIVU, 32'd100, 32'd0);
        wait_done(k, nb);
        total++; if (lo !== 32'hFFFF_FFFF) $display("FAIL divu0_lo: got %h expected ffffffff", lo); else passed++;
        total++; if (hi !== 32'd100) $display("FAIL divu0_hi: got %h expected 00000064", hi); else passed++;
        issue(MULDIV_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        total++; if (done !== 1'b0) $display("FAIL b2b_done: got %b expected 0", done); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b expected 1", busy); else passed++;
        wait_done(k, nb);
        total++; if (k != MulLat) $display("FAIL b2b_latency: got %0d expected %0d", k, MulLat); else passed++;
        total++; if (hi !== 32'hFFFF_FFFE) $display("FAIL b2b_hi: got %h expected fffffffe", hi); else passed++;
        total++; if (lo !== 32'd1) $display("FAIL b2b_lo: got %h expected 00000001", lo); else passed++;
        @(negedge clk);
    endtask

    task automatic test_busy_start();
        int k, nb;
        issue(MULDIV_DIVU, 32'hFFFF_FFFF, 32'd10);
        repeat (4) @(negedge clk);
        issue(MULDIV_MULTU, 32'd3, 32'd3);
        wait_done(k, nb);
        total++; if (k + 5 != DivLat) $display("FAIL busy_start_latency: got %0d expected %0d", k + 5, DivLat); else passed++;
        total++; if (lo !== 32'h1999_9999) $display("FAIL busy_start_lo: got %h expected 19999999", lo); else passed++;
        total++; if (hi !== 32'd5) $display("FAIL busy_start_hi: got %h expected 00000005", hi); else passed++;
        @(negedge clk);
    endtask

    task automatic test_flush();
        int dones;
        issue(MULDIV_DIV, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        funct = MULDIV_MULTU;
        src_a = 32'd4;
        src_b = 32'd4;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        funct = MULDIV_NCARE;
        total++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b expected 0", busy); else passed++;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) dones++;
            @(negedge clk);
        end
        total++; if (dones != 0) $display("FAIL flush_done: got %0d pulses expected 0", dones); else passed++;
        total++; if (hi !== 32'd5) $display("FAIL flush_hi: got %h expected 00000005", hi); else passed++;
        total++; if (lo !== 32'h1999_9999) $display("FAIL flush_lo: got %h expected 19999999", lo); else passed++;
    endtask

    task automatic test_reset_mid();
        int k, nb;
        issue(MULDIV_DIV, 32'd1000, 32'd3);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL rstmid_done: got %b expected 0", done); else passed++;
        total++; if (hi !== 32'd0) $display("FAIL rstmid_hi: got %h expected 0", hi); else passed++;
        total++; if (lo !== 32'd0) $display("FAIL rstmid_lo: got %h expected 0", lo); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(MULDIV_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_done(k, nb);
        total++; if (k != MulLat) $display("FAIL rstmid_mult_latency: got %0d expected %0d", k, MulLat); else passed++;
        total++; if (lo !== 32'hFFFF_FFFA) $display("FAIL rstmid_mult_lo: got %h expected fffffffa", lo); else passed++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_corner();
        test_back_to_back();
        test_busy_start();
        test_flush();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
